// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: per-register enable and flush vectors for cache misses, load-use hazards and taken branches.
// Optional performance counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined; otherwise they read as zero.
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES   = 5,
    parameter int BR_STAGE     = 3,
    parameter int REG_W        = 5,
    parameter int MISS_TIMEOUT = 64,
    parameter int CNT_W        = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  imiss_i,
    input  logic                  dmiss_i,
    input  logic [REG_W-1:0]      id_rs_i,
    input  logic [REG_W-1:0]      id_rt_i,
    input  logic                  ex_memread_i,
    input  logic [REG_W-1:0]      ex_rt_i,
    input  logic                  br_taken_i,
    output logic                  pc_en_o,
    output logic [NUM_STAGES-2:0] reg_en_o,
    output logic [NUM_STAGES-2:0] reg_flush_o,
    output logic                  stalled_o,
    output logic                  err_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    localparam int NR   = NUM_STAGES - 1;
    localparam int MC_W = $clog2(MISS_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_MISS = 2'b01,
        ST_TRAP = 2'b10
    } state_e;

    function automatic logic [NR-1:0] br_mask();
        logic [NR-1:0] m;
        m = '0;
        for (int i = 0; i < NR; i++) begin
            if (i < BR_STAGE) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    localparam logic [NR-1:0] BR_MASK  = br_mask();
    localparam logic [NR-1:0] ALL_ONES = '1;

    state_e            state_q, state_d;
    logic [MC_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic              err_q, err_d;
    logic              miss_s;
    logic              load_use_s;

    assign miss_s     = imiss_i | dmiss_i;
    assign load_use_s = ex_memread_i && (ex_rt_i != '0) &&
                        ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
    assign err_o      = err_q;

    // Next-state and Mealy control outputs; priority TRAP > miss > branch > load-use.
    always_comb begin
        state_d     = state_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = err_q;
        pc_en_o     = 1'b1;
        reg_en_o    = ALL_ONES;
        reg_flush_o = '0;
        stalled_o   = 1'b0;
        if (!rst_i) begin
            pc_en_o     = 1'b0;
            reg_en_o    = '0;
            reg_flush_o = ALL_ONES;
        end else begin
            case (state_q)
                ST_RUN, ST_MISS: begin
                    if (miss_s) begin
                        pc_en_o   = 1'b0;
                        reg_en_o  = '0;
                        stalled_o = 1'b1;
                        state_d   = ST_MISS;
                        if (miss_cnt_q != '1) begin
                            miss_cnt_d = miss_cnt_q + MC_W'(1);
                        end else begin
                            miss_cnt_d = miss_cnt_q;
                        end
                        if (miss_cnt_q >= MC_W'(MISS_TIMEOUT - 1)) begin
                            state_d = ST_TRAP;
                            err_d   = 1'b1;
                        end else begin
                            state_d = ST_MISS;
                        end
                    end else begin
                        state_d    = ST_RUN;
                        miss_cnt_d = '0;
                        if (br_taken_i) begin
                            reg_flush_o = BR_MASK;
                        end else if (load_use_s) begin
                            pc_en_o        = 1'b0;
                            reg_en_o[0]    = 1'b0;
                            reg_flush_o[1] = 1'b1;
                            stalled_o      = 1'b1;
                        end else begin
                            reg_flush_o = '0;
                        end
                    end
                end
                ST_TRAP: begin
                    pc_en_o   = 1'b0;
                    reg_en_o  = '0;
                    stalled_o = 1'b1;
                end
                default: begin
                    // Corrupted state encoding is treated as a fault.
                    pc_en_o   = 1'b0;
                    reg_en_o  = '0;
                    stalled_o = 1'b1;
                    state_d   = ST_TRAP;
                    err_d     = 1'b1;
                end
            endcase
        end
    end

    // State, miss watchdog and sticky error registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_RUN;
            miss_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            miss_cnt_q <= miss_cnt_d;
            err_q      <= err_d;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             br_flush_s;

    // Only a branch flushes register 0 outside reset.
    assign br_flush_s  = rst_i & reg_flush_o[0];
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    // Saturating freeze-cycle and branch-flush counters.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stalled_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
            if (br_flush_s && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end else begin
                flush_cnt_q <= flush_cnt_q;
            end
        end
    end
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: vector table plus multi-cycle sequences, expected values queued at drive time.
module tb_pipe_hazard_ctrl;

    localparam int NR = 4;

    // Expected control pattern kinds
    localparam int K_NORM = 0;
    localparam int K_FRZ  = 1;
    localparam int K_RST  = 2;
    localparam int K_LU   = 3;
    localparam int K_BR   = 4;

    logic            clk = 1'b0;
    logic            rst, imiss, dmiss, ex_memread, br_taken;
    logic [4:0]      id_rs, id_rt, ex_rt;
    logic            pc_en, stalled, err;
    logic [NR-1:0]   reg_en, reg_flush;
    logic [15:0]     stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imiss_i      (imiss),
        .dmiss_i      (dmiss),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .ex_memread_i (ex_memread),
        .ex_rt_i      (ex_rt),
        .br_taken_i   (br_taken),
        .pc_en_o      (pc_en),
        .reg_en_o     (reg_en),
        .reg_flush_o  (reg_flush),
        .stalled_o    (stalled),
        .err_o        (err),
        .stall_cnt_o  (stall_cnt),
        .flush_cnt_o  (flush_cnt)
    );

    typedef struct {
        logic        rst;
        logic        imiss;
        logic        dmiss;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        memread;
        logic [4:0]  exrt;
        logic        br;
        int          kind;
        logic        err;
    } vec_t;

    typedef struct {
        logic          pc;
        logic [NR-1:0] en;
        logic [NR-1:0] fl;
        logic          st;
        logic          err;
        logic [15:0]   scnt;
        logic [15:0]   fcnt;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_err    = 0;
    int     m_scnt   = 0;
    int     m_fcnt   = 0;
    vec_t   tbl[15];

    function automatic vec_t mk(input logic r, input logic im, input logic dm,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic mr, input logic [4:0] er,
                                input logic br, input int kind, input logic e);
        vec_t v;
        v.rst = r; v.imiss = im; v.dmiss = dm; v.rs = rs; v.rt = rt;
        v.memread = mr; v.exrt = er; v.br = br; v.kind = kind; v.err = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e, g;
        rst = v.rst; imiss = v.imiss; dmiss = v.dmiss; id_rs = v.rs; id_rt = v.rt;
        ex_memread = v.memread; ex_rt = v.exrt; br_taken = v.br;
        case (v.kind)
            K_NORM:  begin e.pc = 1'b1; e.en = 4'b1111; e.fl = 4'b0000; e.st = 1'b0; end
            K_FRZ:   begin e.pc = 1'b0; e.en = 4'b0000; e.fl = 4'b0000; e.st = 1'b1; end
            K_RST:   begin e.pc = 1'b0; e.en = 4'b0000; e.fl = 4'b1111; e.st = 1'b0; end
            K_LU:    begin e.pc = 1'b0; e.en = 4'b1110; e.fl = 4'b0010; e.st = 1'b1; end
            default: begin e.pc = 1'b1; e.en = 4'b1111; e.fl = 4'b0111; e.st = 1'b0; end
        endcase
        e.err = v.err;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        e.scnt = 16'(m_scnt);
        e.fcnt = 16'(m_fcnt);
`else
        e.scnt = 16'd0;
        e.fcnt = 16'd0;
`endif
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        chk({tag, ".pc_en"},     {31'd0, pc_en},     {31'd0, g.pc});
        chk({tag, ".reg_en"},    {28'd0, reg_en},    {28'd0, g.en});
        chk({tag, ".reg_flush"}, {28'd0, reg_flush}, {28'd0, g.fl});
        chk({tag, ".stalled"},   {31'd0, stalled},   {31'd0, g.st});
        chk({tag, ".err"},       {31'd0, err},       {31'd0, g.err});
        chk({tag, ".stall_cnt"}, {16'd0, stall_cnt}, {16'd0, g.scnt});
        chk({tag, ".flush_cnt"}, {16'd0, flush_cnt}, {16'd0, g.fcnt});
        if (!v.rst) begin
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            if (g.st) m_scnt++;
            if (g.fl == 4'b0111) m_fcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; imiss = 1'b0; dmiss = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
        ex_memread = 1'b0; ex_rt = 5'd0; br_taken = 1'b0;
        @(posedge clk);
        #1;

        tbl[0]  = mk(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, K_RST,  1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_RST,  1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_NORM, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 5'd8, 5'd2, 1'b1, 5'd8, 1'b0, K_LU,   1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 5'd8, 5'd2, 1'b0, 5'd8, 1'b0, K_NORM, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 5'd3, 5'd5, 1'b1, 5'd5, 1'b0, K_LU,   1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, K_NORM, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 1'b0, 5'd8, 5'd8, 1'b0, 5'd8, 1'b0, K_NORM, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 5'd8, 5'd1, 1'b1, 5'd8, 1'b1, K_BR,   1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, K_BR,   1'b0);
        tbl[10] = mk(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_FRZ,  1'b0);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_NORM, 1'b0);
        tbl[12] = mk(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b1, K_FRZ,  1'b0);
        tbl[13] = mk(1'b1, 1'b0, 1'b0, 5'd1, 5'd8, 1'b1, 5'd8, 1'b0, K_LU,   1'b0);
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 5'd8, 5'd7, 1'b1, 5'd9, 1'b0, K_NORM, 1'b0);
        for (int i = 0; i < 15; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // dmiss for 10 cycles, then free-running
        for (int i = 0; i < 10; i++) begin
            apply(mk(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_FRZ, 1'b0), $sformatf("dmiss%0d", i));
        end
        apply(mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_NORM, 1'b0), "dmiss_end");

        // Branch held through a 3-cycle imiss: single flush afterwards
        for (int i = 0; i < 3; i++) begin
            apply(mk(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, K_FRZ, 1'b0), $sformatf("brmiss%0d", i));
        end
        apply(mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, K_BR,   1'b0), "brmiss_flush");
        apply(mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_NORM, 1'b0), "brmiss_after");

        // Reset in the middle of a miss
        apply(mk(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_FRZ,  1'b0), "rstmiss0");
        apply(mk(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_FRZ,  1'b0), "rstmiss1");
        apply(mk(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_RST,  1'b0), "rstmiss_rst");
        apply(mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_NORM, 1'b0), "rstmiss_after");

        // Watchdog: 64 miss cycles trap, only reset recovers
        for (int i = 0; i < 64; i++) begin
            apply(mk(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_FRZ, 1'b0), $sformatf("tmo%0d", i));
        end
        apply(mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_FRZ,  1'b1), "trap0");
        apply(mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, K_FRZ,  1'b1), "trap_br");
        apply(mk(1'b1, 1'b0, 1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, K_FRZ,  1'b1), "trap_lu");
        apply(mk(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_RST,  1'b1), "trap_rst");
        apply(mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, K_NORM, 1'b0), "trap_after");
        apply(mk(1'b1, 1'b0, 1'b0, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0, K_LU,   1'b0), "trap_after_lu");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
